// File: rtl/ball_pkg.sv
// Shared types and constants for the pong ball controller.
package ball_pkg;

    localparam int COORD_W = 11;

    localparam logic [COORD_W-1:0] X_CENTRE = 11'd504;
    localparam logic [COORD_W-1:0] Y_CENTRE = 11'd376;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SERVE,
        MOVE,
        SCORED
    } ball_state_t;

    function automatic logic [COORD_W-1:0] centre_of(input int active, input int size);
        return COORD_W'((active - size) / 2);
    endfunction

endpackage

// File: rtl/ball_ctl_frame_tick.sv
// Rising-edge detector on vblnk; gives one-cycle frame ticks to the ball and paddle logic.
module frame_tick (
    input  logic clk65MHz,
    input  logic rst,
    input  logic vblnk,
    output logic tick
);

    logic vblnk_q;

    always_ff @(posedge clk65MHz) begin
        if (rst)
            vblnk_q <= 1'b0;
        else
            vblnk_q <= vblnk;
    end

    assign tick = vblnk & ~vblnk_q;

endmodule

// File: rtl/ball_ctl.sv
// Pong ball motion: serve, per-frame step, wall/paddle bounces, miss detection.
// Optional BALL_SPEEDUP_EN: each paddle hit raises speed by one up to SPEED_MAX.
module ball_ctl
    import ball_pkg::*;
#(
    parameter int SIZE_OF_BALL = 15,
    parameter int H_ACTIVE     = 1024,
    parameter int V_ACTIVE     = 768,
    parameter int PADDLE_XL    = 20,
    parameter int PADDLE_XR    = 994,
    parameter int PADDLE_W     = 10,
    parameter int PADDLE_H     = 100,
    parameter int SPEED_INIT   = 4,
    parameter int SPEED_MAX    = 12,
    parameter int SERVE_DELAY  = 60
) (
    input  logic        clk65MHz,
    input  logic        rst,
    input  logic        vblnk,
    input  logic        game_en,
    input  logic        serve,
    input  logic [10:0] y_paddle_l,
    input  logic [10:0] y_paddle_r,
    output logic [10:0] x_pos_of_ball,
    output logic [10:0] y_pos_of_ball,
    output logic        point_l,
    output logic        point_r,
    output logic        ball_active
);

    localparam int SW    = COORD_W + 1;
    localparam int SPD_W = $clog2(SPEED_MAX + 1);
    localparam int DLY_W = $clog2(SERVE_DELAY + 1);

    localparam logic [COORD_W-1:0] X_MID      = centre_of(H_ACTIVE, SIZE_OF_BALL);
    localparam logic [COORD_W-1:0] Y_MID      = centre_of(V_ACTIVE, SIZE_OF_BALL);
    localparam logic [COORD_W-1:0] Y_BOTTOM   = COORD_W'(V_ACTIVE - SIZE_OF_BALL);
    localparam logic [COORD_W-1:0] X_BOUNCE_L = COORD_W'(PADDLE_XL + PADDLE_W);
    localparam logic [COORD_W-1:0] X_BOUNCE_R = COORD_W'(PADDLE_XR - SIZE_OF_BALL);

    localparam logic signed [SW-1:0] X_LIM_S  = SW'(H_ACTIVE - SIZE_OF_BALL);
    localparam logic signed [SW-1:0] Y_LIM_S  = SW'(V_ACTIVE - SIZE_OF_BALL);
    localparam logic signed [SW-1:0] L_EDGE_S = SW'(PADDLE_XL + PADDLE_W);
    localparam logic signed [SW-1:0] R_EDGE_S = SW'(PADDLE_XR);
    localparam logic signed [SW-1:0] SIZE_S   = SW'(SIZE_OF_BALL);

    localparam logic [SPD_W-1:0] SPD_INIT = SPD_W'(SPEED_INIT);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(SERVE_DELAY - 1);

    ball_state_t       state, state_nxt;
    logic [10:0]       x_nxt, y_nxt;
    logic              dir_x, dir_x_nxt, dir_y, dir_y_nxt;
    logic [SPD_W-1:0]  speed, speed_nxt, speed_hit;
    logic [DLY_W-1:0]  delay_cnt, delay_nxt;
    logic              point_l_nxt, point_r_nxt;
    logic              tick;

    logic signed [SW-1:0] x_s, y_s, spd_s, nx, ny;
    logic [SW-1:0]        ball_top, ball_bot;
    logic                 ovl_l, ovl_r, hit_l, hit_r;

    frame_tick u_frame_tick (
        .clk65MHz (clk65MHz),
        .rst      (rst),
        .vblnk    (vblnk),
        .tick     (tick)
    );

    // Candidate step is signed one bit wider so a ball leaving the left/top edge shows up as negative.
    assign x_s   = $signed({1'b0, x_pos_of_ball});
    assign y_s   = $signed({1'b0, y_pos_of_ball});
    assign spd_s = $signed(SW'(speed));
    assign nx    = dir_x ? x_s + spd_s : x_s - spd_s;
    assign ny    = dir_y ? y_s + spd_s : y_s - spd_s;

    assign ball_top = {1'b0, y_pos_of_ball};
    assign ball_bot = ball_top + SW'(SIZE_OF_BALL);
    assign ovl_l    = (ball_top < {1'b0, y_paddle_l} + SW'(PADDLE_H)) && (ball_bot > {1'b0, y_paddle_l});
    assign ovl_r    = (ball_top < {1'b0, y_paddle_r} + SW'(PADDLE_H)) && (ball_bot > {1'b0, y_paddle_r});
    assign hit_l    = !dir_x && (nx <= L_EDGE_S) && (x_s >= L_EDGE_S) && ovl_l;
    assign hit_r    = dir_x && (nx + SIZE_S >= R_EDGE_S) && (x_s + SIZE_S <= R_EDGE_S) && ovl_r;

`ifdef BALL_SPEEDUP_EN
    localparam logic [SPD_W-1:0] SPD_MAX = SPD_W'(SPEED_MAX);
    assign speed_hit = (speed < SPD_MAX) ? speed + 1'b1 : speed;
`else
    assign speed_hit = speed;
`endif

    assign ball_active = (state == MOVE);

    always_comb begin
        state_nxt   = state;
        x_nxt       = x_pos_of_ball;
        y_nxt       = y_pos_of_ball;
        dir_x_nxt   = dir_x;
        dir_y_nxt   = dir_y;
        speed_nxt   = speed;
        delay_nxt   = delay_cnt;
        point_l_nxt = 1'b0;
        point_r_nxt = 1'b0;

        if (!game_en) begin
            state_nxt = IDLE;
            x_nxt     = X_MID;
            y_nxt     = Y_MID;
            speed_nxt = SPD_INIT;
            delay_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = WAIT_SERVE;
                    x_nxt     = X_MID;
                    y_nxt     = Y_MID;
                end
                WAIT_SERVE: begin
                    x_nxt = X_MID;
                    y_nxt = Y_MID;
                    if (serve)
                        state_nxt = MOVE;
                end
                MOVE: begin
                    if (tick) begin
                        if (ny[SW-1]) begin
                            y_nxt     = '0;
                            dir_y_nxt = 1'b1;
                        end else if (ny > Y_LIM_S) begin
                            y_nxt     = Y_BOTTOM;
                            dir_y_nxt = 1'b0;
                        end else begin
                            y_nxt = ny[10:0];
                        end

                        // A miss overrides the wall correction above; dir_y keeps its pre-tick value for the next serve.
                        if (hit_l) begin
                            x_nxt     = X_BOUNCE_L;
                            dir_x_nxt = 1'b1;
                            speed_nxt = speed_hit;
                        end else if (hit_r) begin
                            x_nxt     = X_BOUNCE_R;
                            dir_x_nxt = 1'b0;
                            speed_nxt = speed_hit;
                        end else if (nx[SW-1] || nx > X_LIM_S) begin
                            point_r_nxt = nx[SW-1];
                            point_l_nxt = !nx[SW-1];
                            dir_x_nxt   = !nx[SW-1];
                            dir_y_nxt   = dir_y;
                            x_nxt       = X_MID;
                            y_nxt       = Y_MID;
                            speed_nxt   = SPD_INIT;
                            delay_nxt   = '0;
                            state_nxt   = SCORED;
                        end else begin
                            x_nxt = nx[10:0];
                        end
                    end
                end
                SCORED: begin
                    x_nxt = X_MID;
                    y_nxt = Y_MID;
                    if (tick) begin
                        if (delay_cnt == DLY_LAST) begin
                            delay_nxt = '0;
                            state_nxt = WAIT_SERVE;
                        end else begin
                            delay_nxt = delay_cnt + 1'b1;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk65MHz) begin
        if (rst) begin
            state         <= IDLE;
            x_pos_of_ball <= X_MID;
            y_pos_of_ball <= Y_MID;
            dir_x         <= 1'b1;
            dir_y         <= 1'b1;
            speed         <= SPD_INIT;
            delay_cnt     <= '0;
            point_l       <= 1'b0;
            point_r       <= 1'b0;
        end else begin
            state         <= state_nxt;
            x_pos_of_ball <= x_nxt;
            y_pos_of_ball <= y_nxt;
            dir_x         <= dir_x_nxt;
            dir_y         <= dir_y_nxt;
            speed         <= speed_nxt;
            delay_cnt     <= delay_nxt;
            point_l       <= point_l_nxt;
            point_r       <= point_r_nxt;
        end
    end

endmodule
